// File: rtl/pifo_dequeue_ctrl_pkg.sv
// rtl/pifo_dequeue_ctrl_pkg.sv - shared PIFO info layout, element structs and dequeue buffer depth
package pifo_dequeue_ctrl_pkg;

   localparam int ELEM_W        = 32;
   localparam int RANK_W        = 18;
   localparam int RANK_LSB      = 12;
   localparam int VALID_POS     = 31;
   localparam int OVF_POS       = 30;
   localparam int ADDR_W        = 12;
   localparam int DEQ_BUF_DEPTH = 2;

   typedef struct packed {
      logic              valid;
      logic              overflow;
      logic [RANK_W-1:0] rank;
      logic [ADDR_W-1:0] address;
   } pifo_info_t;

   // What the dequeue buffer keeps of a popped element: the valid bit is implied.
   typedef struct packed {
      logic              overflow;
      logic [RANK_W-1:0] rank;
      logic [ADDR_W-1:0] address;
   } deq_entry_t;

endpackage

// File: rtl/pifo_dequeue_ctrl_if.sv
// rtl/pifo_dequeue_ctrl_if.sv - dequeued-element stream towards the packet-buffer read logic
interface pifo_dequeue_ctrl_if;
   import pifo_dequeue_ctrl_pkg::*;

   logic [ADDR_W-1:0] tdata;
   logic [RANK_W:0]   tuser;
   logic              tvalid;
   logic              tready;

   modport master (output tdata, output tuser, output tvalid, input tready);
   modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface

// File: rtl/pifo_dequeue_ctrl_skid_fifo.sv
// rtl/pifo_dequeue_ctrl_skid_fifo.sv - 2-entry circular output buffer with 1-bit pointers
module pifo_deq_skid_fifo
   import pifo_dequeue_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic       push,
   input  deq_entry_t push_entry,
   input  logic       pull,
   output deq_entry_t head_entry,
   output logic [1:0] count
);

   deq_entry_t mem [DEQ_BUF_DEPTH];
   logic       wr_ptr;
   logic       rd_ptr;

   // Caller guarantees push only when not full and pull only when not empty.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         for (int i = 0; i < DEQ_BUF_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= ~wr_ptr;
         end
         if (pull) rd_ptr <= ~rd_ptr;
         if (push && !pull)      count <= count + 2'd1;
         else if (pull && !push) count <= count - 2'd1;
      end
   end

   assign head_entry = mem[rd_ptr];

endmodule

// File: rtl/pifo_dequeue_ctrl.sv
// rtl/pifo_dequeue_ctrl.sv - head-side PIFO reader; optional calendar gate under PIFO_DEQ_CALENDAR_GATE_EN
module pifo_dequeue_ctrl
   import pifo_dequeue_ctrl_pkg::*;
#(
   parameter int ELEMENT_WIDTH           = ELEM_W,
   parameter int ELEMENT_RANK_WIDTH      = RANK_W,
   parameter int RANK_START_POS          = RANK_LSB,
   parameter int PIFO_INFO_VALID_POS     = VALID_POS,
   parameter int PIFO_INFO_OVERFLOW_POS  = OVF_POS,
   parameter int PIFO_INFO_ADDRESS_WIDTH = ADDR_W,
   parameter int COUNT_WIDTH             = 32
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic [ELEMENT_WIDTH-1:0]      in_head_element,
   input  logic                          in_deq_enable,
   input  logic [ELEMENT_RANK_WIDTH-1:0] in_current_time,
   input  logic                          in_time_wrap,
   output logic                          out_ctl_pop,
   output logic                          out_global_overflow_bit,
   pifo_dequeue_ctrl_if.master           m_axis,
   output logic [COUNT_WIDTH-1:0]        out_deq_count,
   output logic                          out_empty
);

   localparam logic [1:0] BUF_FULL = 2'(DEQ_BUF_DEPTH);

   logic                          head_valid;
   logic                          head_ovf;
   logic [ELEMENT_RANK_WIDTH-1:0] head_rank;
   deq_entry_t                    head_entry;
   deq_entry_t                    buf_entry;
   logic [1:0]                    buf_count;
   logic                          eligible;
   logic                          handshake;

   assign head_valid = in_head_element[PIFO_INFO_VALID_POS];
   assign head_ovf   = in_head_element[PIFO_INFO_OVERFLOW_POS];
   assign head_rank  = in_head_element[RANK_START_POS +: ELEMENT_RANK_WIDTH];
   assign head_entry = '{overflow: head_ovf,
                         rank:     head_rank,
                         address:  in_head_element[PIFO_INFO_ADDRESS_WIDTH-1:0]};

`ifdef PIFO_DEQ_CALENDAR_GATE_EN
   // Same round: wait until due. Other round: only drain what belongs to the round being served.
   assign eligible = (head_ovf == in_time_wrap) ? (head_rank <= in_current_time)
                                                : (head_ovf == out_global_overflow_bit);
`else
   logic unused_gate;
   assign unused_gate = ^{in_current_time, in_time_wrap};
   assign eligible    = 1'b1;
`endif

   // Pop depends only on buffer occupancy, never on tready, so no ready path reaches the chain.
   assign out_ctl_pop = rstn & head_valid & in_deq_enable & eligible & (buf_count < BUF_FULL);
   assign out_empty   = ~rstn | (~head_valid & (buf_count == 2'd0));

   assign m_axis.tvalid = (buf_count != 2'd0);
   assign m_axis.tdata  = buf_entry.address;
   assign m_axis.tuser  = {buf_entry.overflow, buf_entry.rank};
   assign handshake     = m_axis.tvalid & m_axis.tready;

   pifo_deq_skid_fifo u_buf (
      .clk        (clk),
      .rstn       (rstn),
      .push       (out_ctl_pop),
      .push_entry (head_entry),
      .pull       (handshake),
      .head_entry (buf_entry),
      .count      (buf_count)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         out_global_overflow_bit <= 1'b0;
         out_deq_count           <= '0;
      end else if (out_ctl_pop) begin
         out_global_overflow_bit <= head_ovf;
         if (out_deq_count != '1) out_deq_count <= out_deq_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_pifo_dequeue_ctrl.sv
// tb/tb_pifo_dequeue_ctrl.sv - self-checking bench for pifo_dequeue_ctrl against a queue model
module tb_pifo_dequeue_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] head;
   logic        deq_en;
   logic [17:0] cur_time;
   logic        time_wrap;
   logic        ctl_pop;
   logic        glob_ovf;
   logic [31:0] deq_count;
   logic        empty;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [30:0] mq[$];
   logic        m_ovf;
   logic [31:0] m_cnt;

   pifo_dequeue_ctrl_if m_axis ();

   pifo_dequeue_ctrl dut (
      .clk                     (clk),
      .rstn                    (rstn),
      .in_head_element         (head),
      .in_deq_enable           (deq_en),
      .in_current_time         (cur_time),
      .in_time_wrap            (time_wrap),
      .out_ctl_pop             (ctl_pop),
      .out_global_overflow_bit (glob_ovf),
      .m_axis                  (m_axis),
      .out_deq_count           (deq_count),
      .out_empty               (empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic v, input logic o, input logic [17:0] r,
                                      input logic [11:0] a);
      return {v, o, r, a};
   endfunction

   function automatic bit elig(input logic [31:0] h);
`ifdef PIFO_DEQ_CALENDAR_GATE_EN
      if (h[30] == time_wrap) return int'(h[29:12]) <= int'(cur_time);
      return h[30] == m_ovf;
`else
      return (h[31] | ~h[31]);
`endif
   endfunction

   // One clock: drive inputs, check combinational/buffered outputs, advance model, check registers.
   task automatic step(input logic [31:0] h, input logic en, input logic rdy);
      logic exp_pop;
      logic exp_hs;
      head          = h;
      deq_en        = en;
      m_axis.tready = rdy;
      #1;
      exp_pop = h[31] && en && elig(h) && (mq.size() < 2);
      exp_hs  = (mq.size() != 0) && rdy;
      chk("pop", ctl_pop, exp_pop);
      chk("tvalid", m_axis.tvalid, mq.size() != 0);
      if (mq.size() != 0) begin
         chk("tdata", m_axis.tdata, mq[0][11:0]);
         chk("tuser", m_axis.tuser, mq[0][30:12]);
      end
      chk("empty", empty, !h[31] && mq.size() == 0);
      @(posedge clk);
      #1;
      if (exp_hs) void'(mq.pop_front());
      if (exp_pop) begin
         mq.push_back(h[30:0]);
         m_ovf = h[30];
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end
      chk("glob_ovf", glob_ovf, m_ovf);
      chk("deq_count", deq_count, m_cnt);
   endtask

   initial begin
      rstn          = 1'b0;
      head          = 32'h8000_1005;
      deq_en        = 1'b1;
      cur_time      = '0;
      time_wrap     = 1'b0;
      m_axis.tready = 1'b1;
      m_ovf         = 1'b0;
      m_cnt         = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pop", ctl_pop, 0);
      chk("rst_glob_ovf", glob_ovf, 0);
      chk("rst_tvalid", m_axis.tvalid, 0);
      chk("rst_tdata", m_axis.tdata, 0);
      chk("rst_tuser", m_axis.tuser, 0);
      chk("rst_count", deq_count, 0);
      chk("rst_empty", empty, 1);
      rstn = 1'b1;

      step(32'h8000_1005, 1, 1);
      for (int i = 0; i < 4; i++)
         step(mk(1, 0, 18'($urandom_range(0, 1000)), 12'($urandom)), 1, 1);

      for (int i = 0; i < 4; i++)
         step(mk(1, 0, 18'(i + 10), 12'(12'h100 + i)), 1, 0);
      for (int i = 0; i < 5; i++)
         step(mk(1, 0, 18'(i + 20), 12'(12'h200 + i)), 1, 1);

      step(32'hC000_3007, 1, 1);
      step(32'h8000_2008, 1, 1);
      step(32'h8000_2009, 0, 1);
      for (int i = 0; i < 3; i++) step(32'h0000_0000, 1, 1);

`ifdef PIFO_DEQ_CALENDAR_GATE_EN
      time_wrap = 1'b0;
      cur_time  = 18'd99;
      step(mk(1, 0, 18'd100, 12'h0AA), 1, 1);
      cur_time  = 18'd100;
      step(mk(1, 0, 18'd100, 12'h0AA), 1, 1);
      step(mk(1, 1, 18'd100, 12'h0AB), 1, 1);
      time_wrap = 1'b1;
      cur_time  = 18'd200;
      step(mk(1, 1, 18'd100, 12'h0AC), 1, 1);
      time_wrap = 1'b0;
      cur_time  = 18'd5;
      step(mk(1, 1, 18'd150, 12'h0AD), 1, 1);
      step(32'h0000_0000, 1, 1);
`endif

      for (int i = 0; i < 300; i++) begin
         cur_time  = 18'($urandom_range(0, 300));
         time_wrap = 1'($urandom_range(0, 1));
         step(mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 18'($urandom_range(0, 300)), 12'($urandom)),
              $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
